// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake direction queue.
// Direction codes match the move register encoding used by the processor.
package snake_pkg;

    localparam int DIR_W = 3;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_NONE  = 3'd0;
    localparam dir_t DIR_UP    = 3'd1;
    localparam dir_t DIR_RIGHT = 3'd2;
    localparam dir_t DIR_DOWN  = 3'd3;
    localparam dir_t DIR_LEFT  = 3'd4;

    function automatic dir_t opposite(input dir_t dir);
        case (dir)
            DIR_UP:    return DIR_DOWN;
            DIR_RIGHT: return DIR_LEFT;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// One button: 2-flop synchroniser, optional debounce counter, one-cycle press pulse.
// Debounce counter present only when SNAKE_DIR_QUEUE_DEBOUNCE_EN is defined.
module snake_btn_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic resetn,
    input  logic btn_n,
    output logic press
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

`ifdef SNAKE_DIR_QUEUE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic             level;

    // Level follows sync2 only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 != level) begin
                if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    count <= '0;
                    level <= sync2;
                    press <= level;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end
`else
    logic last;

    // DEBOUNCE_CYCLES is at least 1, so the range term is constant-true here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last  <= 1'b1;
            press <= 1'b0;
        end else begin
            last  <= sync2;
            press <= last & ~sync2 & (DEBOUNCE_CYCLES >= 1);
        end
    end
`endif

endmodule

// File: rtl/snake_dir_queue.sv
// Per-player turn queue: debounced presses, reversal rejection, tick-driven commit.
// Build option SNAKE_DIR_QUEUE_DEBOUNCE_EN enables the debounce counters.
module snake_dir_queue
    import snake_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int QUEUE_DEPTH     = 2,
    parameter int INIT_DIR        = 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [4*NUM_PLAYERS-1:0] btn_n,
    input  logic                     tick,
    input  logic                     clear,
    output logic [32*NUM_PLAYERS-1:0] move_out,
    output logic [NUM_PLAYERS-1:0]   pending,
    output logic [NUM_PLAYERS-1:0]   ovf
);

    localparam int   PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int   OCC_W    = $clog2(QUEUE_DEPTH) + 1;
    localparam dir_t INIT_VAL = DIR_W'(INIT_DIR);

    logic [4*NUM_PLAYERS-1:0] press;

    for (genvar b = 0; b < 4*NUM_PLAYERS; b++) begin : g_btn
        snake_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clock  (clock),
            .resetn (resetn),
            .btn_n  (btn_n[b]),
            .press  (press[b])
        );
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        dir_t             slots [QUEUE_DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] tail_ptr;
        logic [OCC_W-1:0] occupancy;
        dir_t             move;
        logic             ovf_flag;
        logic [3:0]       btn_press;
        dir_t             cand;
        dir_t             ref_dir;
        logic             accept;
        logic             full;
        logic             do_push;
        logic             do_pop;

        assign btn_press = press[4*p +: 4];

        // Reference is the newest queued turn, so reversals are judged against what the snake will do.
        always_comb begin
            tail_ptr = (wr_ptr == '0) ? PTR_W'(QUEUE_DEPTH - 1) : wr_ptr - 1'b1;
            ref_dir  = (occupancy != '0) ? slots[tail_ptr] : move;
            if (btn_press[0])      cand = DIR_UP;
            else if (btn_press[1]) cand = DIR_RIGHT;
            else if (btn_press[2]) cand = DIR_DOWN;
            else if (btn_press[3]) cand = DIR_LEFT;
            else                   cand = DIR_NONE;
            accept  = (cand != DIR_NONE) && (cand != ref_dir) && (cand != opposite(ref_dir));
            full    = (occupancy == OCC_W'(QUEUE_DEPTH));
            do_pop  = tick && (occupancy != '0);
            do_push = accept && (!full || tick);
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) slots[i] <= DIR_NONE;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
                move      <= INIT_VAL;
                ovf_flag  <= 1'b0;
            end else if (clear) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
                move      <= INIT_VAL;
                ovf_flag  <= 1'b0;
            end else begin
                if (do_pop) begin
                    move   <= slots[rd_ptr];
                    rd_ptr <= next_ptr(rd_ptr);
                end
                if (do_push) begin
                    slots[wr_ptr] <= cand;
                    wr_ptr        <= next_ptr(wr_ptr);
                end
                if (accept && full && !tick) ovf_flag <= 1'b1;
                if (do_push && !do_pop)      occupancy <= occupancy + 1'b1;
                else if (do_pop && !do_push) occupancy <= occupancy - 1'b1;
            end
        end

        assign move_out[32*p +: 32] = {{(32-DIR_W){1'b0}}, move};
        assign pending[p]           = (occupancy != '0);
        assign ovf[p]               = ovf_flag;
    end

endmodule
